// File: rtl/iq_mixer_rx_pkg.sv
// iq_mixer_rx_pkg: shared widths, DDS beat layout and clamp helper for the IQ receive mixer
package iq_mixer_rx_pkg;
  localparam int DATA_W_D = 16;
  localparam int DDS_W_D = 16;
  localparam int OUT_W_D = 16;
  typedef logic signed [DATA_W_D-1:0] sample_t;
  typedef logic signed [DDS_W_D-1:0] dds_t;
  typedef struct packed {
    dds_t sin;
    dds_t cos;
  } dds_beat_t;
  typedef logic signed [DATA_W_D+DDS_W_D:0] prod_t;
  typedef logic signed [OUT_W_D-1:0] out_t;
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/iq_mixer_rx_join_fifo.sv
// iq_mixer_rx_join_fifo: show-ahead synchronous FIFO holding one input stream until its partner arrives
module iq_mixer_rx_join_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/iq_mixer_rx_pipe.sv
// iq_mixer_rx_pipe: joins sample and DDS streams, mixes to I/Q with gain shift; IQ_MIXER_RX_SAT_EN selects clamping over wrap
module iq_mixer_rx_pipe import iq_mixer_rx_pkg::*; #(
  parameter int DATA_W = DATA_W_D,
  parameter int DDS_W = DDS_W_D,
  parameter int OUT_W = OUT_W_D,
  parameter int FIFO_DEPTH = 4,
  parameter int GAIN_W = 3
) (
  input  logic                axis_aclk,
  input  logic                axis_areset,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [2*DDS_W-1:0]  s_axis_dds_tdata,
  input  logic                s_axis_dds_tvalid,
  output logic                s_axis_dds_tready,
  output logic [OUT_W-1:0]    m_axis_real_tdata,
  output logic [OUT_W-1:0]    m_axis_imag_tdata,
  output logic                m_axis_real_tvalid,
  output logic                m_axis_imag_tvalid,
  input  logic                m_axis_tready,
  input  logic [GAIN_W-1:0]   i_gain_shift,
  output logic                o_sat
);
  localparam int PW = DATA_W + DDS_W + 1;
  localparam int SW = PW + (1 << GAIN_W) - 1;
  logic rdy_en, x_full, x_empty, d_full, d_empty, en, pop, v1, v2, out_v;
  logic [DATA_W-1:0] x_q;
  logic [2*DDS_W-1:0] d_q;
  logic signed [DATA_W-1:0] x1;
  logic signed [DDS_W-1:0] c1, s1;
  logic [GAIN_W-1:0] g1, g2;
  logic signed [PW-1:0] pr2, pi2;
  logic signed [SW-1:0] sr, si;
  // ready is held low until the first edge after reset releases
  assign s_axis_tready = rdy_en && !x_full;
  assign s_axis_dds_tready = rdy_en && !d_full;
  assign en = !(out_v && !m_axis_tready);
  assign pop = en && !x_empty && !d_empty;
  assign m_axis_real_tvalid = out_v;
  assign m_axis_imag_tvalid = out_v;
  assign sr = (SW'(pr2) <<< g2) >>> (DDS_W - 1);
  assign si = (SW'(pi2) <<< g2) >>> (DDS_W - 1);
  iq_mixer_rx_join_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_x_fifo (
    .clk(axis_aclk), .rst(axis_areset), .push(s_axis_tvalid && s_axis_tready),
    .din(s_axis_tdata), .pop(pop), .dout(x_q), .full(x_full), .empty(x_empty)
  );
  iq_mixer_rx_join_fifo #(.W(2*DDS_W), .DEPTH(FIFO_DEPTH)) u_d_fifo (
    .clk(axis_aclk), .rst(axis_areset), .push(s_axis_dds_tvalid && s_axis_dds_tready),
    .din(s_axis_dds_tdata), .pop(pop), .dout(d_q), .full(d_full), .empty(d_empty)
  );
`ifdef IQ_MIXER_RX_SAT_EN
  logic signed [63:0] cr, ci;
  assign cr = saturate(64'(sr), OUT_W);
  assign ci = saturate(64'(si), OUT_W);
  always_ff @(posedge axis_aclk or posedge axis_areset)
    if (axis_areset) o_sat <= 1'b0;
    else if (en && v2 && (cr != 64'(sr) || ci != 64'(si))) o_sat <= 1'b1;
`else
  assign o_sat = 1'b0;
`endif
  always_ff @(posedge axis_aclk or posedge axis_areset)
    if (axis_areset) begin
      rdy_en <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_v <= 1'b0;
      x1 <= '0;
      c1 <= '0;
      s1 <= '0;
      g1 <= '0;
      g2 <= '0;
      pr2 <= '0;
      pi2 <= '0;
      m_axis_real_tdata <= '0;
      m_axis_imag_tdata <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (en) begin
        v1 <= pop;
        x1 <= x_q;
        c1 <= d_q[DDS_W-1:0];
        s1 <= d_q[2*DDS_W-1:DDS_W];
        g1 <= i_gain_shift;
        v2 <= v1;
        pr2 <= PW'(x1) * PW'(c1);
        pi2 <= -(PW'(x1) * PW'(s1));
        g2 <= g1;
        out_v <= v2;
`ifdef IQ_MIXER_RX_SAT_EN
        m_axis_real_tdata <= OUT_W'(cr);
        m_axis_imag_tdata <= OUT_W'(ci);
`else
        m_axis_real_tdata <= OUT_W'(sr);
        m_axis_imag_tdata <= OUT_W'(si);
`endif
      end
    end
endmodule

// File: tb/tb_iq_mixer_rx_pipe.sv
// tb_iq_mixer_rx_pipe: vector table, corner sequences and randomized scoreboard for iq_mixer_rx_pipe
module tb_iq_mixer_rx_pipe;
  import iq_mixer_rx_pkg::*;
`ifdef IQ_MIXER_RX_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] s_tdata, m_real, m_imag;
  logic s_tvalid, s_tready, d_tvalid, d_tready, m_rv, m_iv, m_tready, o_sat;
  logic [2:0] gain;
  dds_beat_t beat;
  int errs = 0, checks = 0;
  bit mon_en = 1'b0, msat;
  int xq[$], eq_r[$], eq_i[$];
  dds_beat_t dq[$];
  typedef struct {
    int x, c, s, g, er, ei;
    bit es;
  } vec_t;
  vec_t vt[6];

  iq_mixer_rx_pipe dut (
    .axis_aclk(clk), .axis_areset(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_dds_tdata(beat), .s_axis_dds_tvalid(d_tvalid), .s_axis_dds_tready(d_tready),
    .m_axis_real_tdata(m_real), .m_axis_imag_tdata(m_imag),
    .m_axis_real_tvalid(m_rv), .m_axis_imag_tvalid(m_iv),
    .m_axis_tready(m_tready), .i_gain_shift(gain), .o_sat(o_sat)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // floor(p * 2^g / 2^15), then clamp or wrap to 16 bits
  function automatic int red(input longint p, input int g, inout bit st);
    longint v, q;
    v = p * (longint'(1) << g);
    q = v / 32768;
    if (v < 0 && q * 32768 != v) q -= 1;
    if (SAT) begin
      if (q > 32767) begin q = 32767; st = 1'b1; end
      else if (q < -32768) begin q = -32768; st = 1'b1; end
      return int'(q);
    end
    q = q & 65535;
    if (q > 32767) q -= 65536;
    return int'(q);
  endfunction

  always @(negedge clk) begin : mon
    int x;
    dds_beat_t b;
    if (mon_en) begin
      if (s_tvalid && s_tready) xq.push_back(int'($signed(s_tdata)));
      if (d_tvalid && d_tready) dq.push_back(beat);
      if (m_rv && m_tready) begin
        if (eq_r.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL rnd_extra: got output %0d expected none", $signed(m_real));
        end else begin
          chk("rnd_real", $signed(m_real), eq_r.pop_front());
          chk("rnd_imag", $signed(m_imag), eq_i.pop_front());
          chk("rnd_ivalid", m_iv, 1);
        end
      end
      while (xq.size() > 0 && dq.size() > 0) begin
        x = xq.pop_front();
        b = dq.pop_front();
        eq_r.push_back(red(longint'(x) * b.cos, int'(gain), msat));
        eq_i.push_back(red(-(longint'(x) * b.sin), int'(gain), msat));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    int n = 0;
    s_tdata = 16'(v.x);
    beat.cos = 16'(v.c);
    beat.sin = 16'(v.s);
    gain = 3'(v.g);
    s_tvalid = 1'b1;
    d_tvalid = 1'b1;
    chk($sformatf("vec%0d_rdy", i), s_tready && d_tready, 1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    d_tvalid = 1'b0;
    while (!m_rv && n < 10) begin @(posedge clk); #1; n++; end
    chk($sformatf("vec%0d_lat", i), n, 3);
    chk($sformatf("vec%0d_real", i), $signed(m_real), v.er);
    chk($sformatf("vec%0d_imag", i), $signed(m_imag), v.ei);
    chk($sformatf("vec%0d_sat", i), o_sat, v.es);
    @(posedge clk); #1;
    chk($sformatf("vec%0d_drop", i), m_rv, 0);
  endtask

  initial begin
    int acc_s, acc_d, got, n, seen;
    bit hs_s, hs_d;
    s_tvalid = 0; d_tvalid = 0; m_tready = 1; gain = 0; s_tdata = 0; beat = '0;
    vt[0] = '{1000, 16384, -16384, 0, 500, 500, 1'b0};
    vt[1] = '{1000, 16384, -16384, 2, 2000, 2000, 1'b0};
    vt[2] = '{32767, 32767, 0, 3, SAT ? 32767 : -16, 0, SAT};
    vt[3] = '{-32768, -32768, -32768, 0, SAT ? 32767 : -32768, -32768, SAT};
    vt[4] = '{-1000, 16384, 16384, 0, -500, 500, SAT};
    vt[5] = '{3, 1, 1, 0, 0, -1, SAT};
    repeat (2) @(posedge clk); #1;
    chk("rst_valid", m_rv, 0);
    chk("rst_real", m_real, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_tready", s_tready, 0);
    rst = 1'b0;
    #1 chk("rel_tready_low", s_tready, 0);
    @(posedge clk); #1;
    chk("rel_tready_high", s_tready && d_tready, 1);
    for (int i = 0; i < 6; i++) run_vec(vt[i], i);
    // sample arrives long before its DDS beat
    do_reset();
    gain = 0; s_tdata = 16'd1000; beat.cos = 16'sd16384; beat.sin = -16'sd16384;
    s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; seen += int'(m_rv); end
    chk("late_no_early_out", seen, 0);
    chk("late_dds_ready", d_tready, 1);
    d_tvalid = 1'b1;
    @(posedge clk); #1;
    d_tvalid = 1'b0;
    n = 0;
    while (!m_rv && n < 10) begin @(posedge clk); #1; n++; end
    chk("late_lat", n, 3);
    chk("late_real", $signed(m_real), 500);
    seen = 0;
    repeat (6) begin @(posedge clk); #1; seen += int'(m_rv); end
    chk("late_single", seen, 0);
    // full stall: capacity, then ordered release
    do_reset();
    m_tready = 1'b0; acc_s = 0; acc_d = 0;
    s_tdata = 16'd100; s_tvalid = 1'b1; d_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hs_s = s_tready;
      hs_d = d_tready;
      @(posedge clk); #1;
      if (hs_s) begin acc_s++; s_tdata = 16'(100 * (acc_s + 1)); end
      if (hs_d) acc_d++;
    end
    chk("bp_acc_s", acc_s, 7);
    chk("bp_acc_d", acc_d, 7);
    chk("bp_tready_low", s_tready || d_tready, 0);
    chk("bp_hold", $signed(m_real), 50);
    s_tvalid = 1'b0; d_tvalid = 1'b0; m_tready = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_rv && m_tready) begin
        chk($sformatf("bp_out%0d", got), $signed(m_real), 50 * (got + 1));
        got++;
      end
    end
    chk("bp_count", got, 7);
    // reset in the middle of a burst
    m_tready = 1'b0; s_tdata = 16'd100; s_tvalid = 1'b1; d_tvalid = 1'b1;
    repeat (12) @(posedge clk);
    #1 m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    s_tvalid = 1'b0; d_tvalid = 1'b0;
    #1;
    chk("mid_rst_valid", m_rv, 0);
    chk("mid_rst_real", m_real, 0);
    chk("mid_rst_tready", s_tready, 0);
    @(posedge clk); #1;
    chk("mid_rst_imag", m_imag, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready_back", s_tready && d_tready, 1);
    seen = 0;
    repeat (15) begin @(posedge clk); #1; seen += int'(m_rv); end
    chk("mid_rst_no_stale", seen, 0);
    // randomized traffic against the arithmetic model
    do_reset();
    msat = 1'b0; xq.delete(); dq.delete(); eq_r.delete(); eq_i.delete();
    mon_en = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      gain = 3'($urandom_range(0, 7));
      for (int i = 0; i < 300; i++) begin
        @(posedge clk); #1;
        s_tvalid = $urandom_range(0, 9) < 3 + 2 * ph;
        d_tvalid = $urandom_range(0, 9) < 8 - ph;
        s_tdata = ph == 2 ? ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000) : 16'($urandom);
        beat = 32'($urandom);
        m_tready = $urandom_range(0, 9) < (ph == 1 ? 2 : 8);
      end
      s_tvalid = 1'b0; d_tvalid = 1'b0; m_tready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk($sformatf("rnd_drain%0d", ph), eq_r.size(), 0);
      chk($sformatf("rnd_sat%0d", ph), o_sat, msat);
    end
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish within 200000 time units");
    $fatal(1);
  end
endmodule
